// File: rtl/miniRV_pkg.sv
// miniRV_pkg: shared types and constants for the miniRV fetch path.
//   fetch_state_t    - fetch/execute sequencer states
//   INSTR_BYTES      - size of one instruction word in bytes
//   FETCH_ALIGN_MASK - address bits that must be zero for a legal fetch target
//   fetch_aligned()  - helper that tests an address against FETCH_ALIGN_MASK
package miniRV_pkg;

   localparam int unsigned INSTR_BYTES      = 4;
   localparam logic [31:0] FETCH_ALIGN_MASK = 32'(INSTR_BYTES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StWaitData,
      StIssue,
      StExec,
      StHalted,
      StFault
   } fetch_state_t;

   function automatic logic fetch_aligned(input logic [31:0] addr);
      return (addr & FETCH_ALIGN_MASK) == 32'h0;
   endfunction

endpackage

// File: rtl/wait_timer.sv
// wait_timer: bounded-wait counter for the fetch handshake.
//   clk      in  - core clock
//   reset_n  in  - asynchronous active-low reset
//   clear    in  - return the count to zero
//   enable   in  - count this cycle
//   expired  out - the current cycle is the MAX_WAIT-th counted cycle (or later)
module wait_timer #(
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   // count_q holds the number of cycles already spent, so the MAX_WAIT-th
   // cycle is the one where count_q == MAX_WAIT-1.
   localparam logic [7:0] LAST_COUNT = 8'(MAX_WAIT - 1);

   logic [7:0] count_q, count_d;

   assign expired = (count_q >= LAST_COUNT);

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = 8'd0;
      end else if (enable && !expired) begin
         // Saturate so expired stays asserted until cleared.
         count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: multi-cycle fetch/execute sequencer for the miniRV core.
// Drives the pc register's load controls, fetches one instruction at a time
// from instruction memory, offers it to execute and advances the PC only when
// execute reports completion.
//   clk, reset_n              - core clock, asynchronous active-low reset
//   pc_addr                   - current PC from the pc register
//   pc_in_addr, pc_is_addr    - pc register load value / load select (0 = PC+4)
//   imem_req, imem_addr       - fetch request and address
//   imem_gnt                  - request accepted
//   imem_rvalid, imem_rdata   - read response
//   instr_valid, instr        - instruction offered to execute
//   instr_pc                  - PC of instr
//   exec_ready, exec_done     - execute accept / completion
//   redirect_valid/_addr      - redirect target, qualified by exec_done
//   halt                      - stop fetching
//   busy, fault               - activity status, sticky error
module fetch_ctrl
   import miniRV_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] pc_addr,
   output logic [31:0] pc_in_addr,
   output logic        pc_is_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        exec_ready,
   input  logic        exec_done,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_addr,
   input  logic        halt,
   output logic        busy,
   output logic        fault
);

   fetch_state_t state_q, state_d;
   logic [31:0]  instr_q, instr_pc_q;
   logic         capture;
   logic         in_fetch;
   logic         wait_expired;

   // The timer runs only while a fetch is outstanding; leaving REQ/WAIT_DATA
   // clears it, so it always starts from zero on entry to REQ.
   assign in_fetch = (state_q == StReq) || (state_q == StWaitData);

   wait_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (!in_fetch),
      .enable  (in_fetch),
      .expired (wait_expired)
   );

   always_comb begin
      state_d     = state_q;
      pc_is_addr  = 1'b1;
      pc_in_addr  = pc_addr;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      capture     = 1'b0;

      unique case (state_q)
         StIdle: begin
            state_d = halt ? StHalted : StReq;
         end
         StReq: begin
            imem_req = 1'b1;
            if (imem_gnt) begin
               state_d = StWaitData;
            end else if (wait_expired) begin
               state_d = StFault;
            end
         end
         StWaitData: begin
            if (imem_rvalid) begin
               capture = 1'b1;
               state_d = StIssue;
            end else if (wait_expired) begin
               state_d = StFault;
            end
         end
         StIssue: begin
            instr_valid = 1'b1;
            // exec_done here is deliberately ignored: completion only counts
            // once the instruction has been accepted.
            if (exec_ready) begin
               state_d = StExec;
            end
         end
         StExec: begin
            if (exec_done) begin
               if (redirect_valid) begin
                  if (fetch_aligned(redirect_addr)) begin
                     pc_in_addr = redirect_addr;
                     state_d    = halt ? StHalted : StReq;
                  end else begin
                     state_d = StFault;
                  end
               end else begin
                  pc_is_addr = 1'b0;
                  state_d    = halt ? StHalted : StReq;
               end
            end
         end
         StHalted: begin
            if (!halt) begin
               state_d = StReq;
            end
         end
         StFault: begin
            state_d = StFault;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Captured instruction stays put from ISSUE until the next fetch returns.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         instr_q    <= 32'h0;
         instr_pc_q <= 32'h0;
      end else if (capture) begin
         instr_q    <= imem_rdata;
         instr_pc_q <= pc_addr;
      end
   end

   assign imem_addr = pc_addr;
   assign instr     = instr_q;
   assign instr_pc  = instr_pc_q;
   assign busy      = (state_q != StHalted) && (state_q != StFault);
   assign fault     = (state_q == StFault);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized self-checking bench for fetch_ctrl. The bench owns
// a pc register model, drives per-instruction transactions with chosen memory
// and execute latencies, and predicts outputs from a transaction-level model.
module tb_fetch_ctrl;

   localparam int unsigned MAX_WAIT = 16;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] pc_addr;
   logic [31:0] pc_in_addr;
   logic        pc_is_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        exec_ready;
   logic        exec_done;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic        halt;
   logic        busy;
   logic        fault;

   int          n_checks = 0;
   int          n_errors = 0;

   // Transaction-level model state.
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_ipc;

   always #5 clk = ~clk;

   // Environment pc register.
   logic [31:0] pc_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) pc_q <= RESET_PC;
      else          pc_q <= pc_is_addr ? pc_in_addr : pc_q + 32'd4;
   end
   assign pc_addr = pc_q;

   fetch_ctrl #(
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .pc_addr        (pc_addr),
      .pc_in_addr     (pc_in_addr),
      .pc_is_addr     (pc_is_addr),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .exec_ready     (exec_ready),
      .exec_done      (exec_done),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .halt           (halt),
      .busy           (busy),
      .fault          (fault)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      imem_rdata     = 32'h0;
      exec_ready     = 1'b0;
      exec_done      = 1'b0;
      redirect_valid = 1'b0;
      redirect_addr  = 32'h0;
      halt           = 1'b0;
   endtask

   // Noise on inputs the current state must ignore.
   task automatic noise_exec();
      exec_ready     = 1'($urandom_range(0, 1));
      exec_done      = 1'($urandom_range(0, 1));
      redirect_valid = 1'($urandom_range(0, 1));
      redirect_addr  = $urandom;
   endtask

   task automatic do_halt(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         halt        = 1'b1;
         exec_done   = 1'b0;
         imem_gnt    = 1'($urandom_range(0, 1));
         imem_rvalid = 1'($urandom_range(0, 1));
         imem_rdata  = $urandom;
         #1;
         check_val("halt_busy", 32'(busy), 32'd0);
         check_val("halt_req", 32'(imem_req), 32'd0);
         check_val("halt_fault", 32'(fault), 32'd0);
         check_val("halt_pc_is", 32'(pc_is_addr), 32'd1);
         check_val("halt_pc", pc_in_addr, m_pc);
         check_val("halt_instr", instr, m_instr);
      end
      @(negedge clk);
      halt        = 1'b0;
      imem_rvalid = 1'b0;
      #1;
      check_val("halt_exit_busy", 32'(busy), 32'd0);
   endtask

   task automatic do_reset(input bit hlt_idle);
      @(negedge clk);
      reset_n = 1'b0;
      idle_inputs();
      #1;
      m_pc    = RESET_PC;
      m_instr = 32'h0;
      m_ipc   = 32'h0;
      check_val("rst_req", 32'(imem_req), 32'd0);
      check_val("rst_ivalid", 32'(instr_valid), 32'd0);
      check_val("rst_instr", instr, 32'h0);
      check_val("rst_instr_pc", instr_pc, 32'h0);
      check_val("rst_fault", 32'(fault), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd1);
      check_val("rst_pc_is", 32'(pc_is_addr), 32'd1);
      check_val("rst_pc_in", pc_in_addr, RESET_PC);
      // First cycle after release: IDLE, with a stray response that must drop.
      @(negedge clk);
      reset_n     = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
      halt        = hlt_idle;
      #1;
      check_val("idle_req", 32'(imem_req), 32'd0);
      check_val("idle_busy", 32'(busy), 32'd1);
      if (hlt_idle) do_halt(2);
   endtask

   // One instruction: gnt after gl idle REQ cycles, rvalid after rl WAIT cycles,
   // ready after yl ISSUE cycles, done after dl EXEC cycles.
   task automatic fetch_one(input int gl, input int rl, input int yl, input int dl,
                            input bit redir, input logic [31:0] tgt, input bit hlt);
      logic [31:0] word;
      logic [31:0] next_pc;
      word = $urandom;
      for (int i = 0; i <= gl; i++) begin
         @(negedge clk);
         imem_gnt    = (i == gl);
         imem_rvalid = 1'($urandom_range(0, 1));
         imem_rdata  = $urandom;
         halt        = 1'($urandom_range(0, 1));
         noise_exec();
         #1;
         check_val("req", 32'(imem_req), 32'd1);
         check_val("req_addr", imem_addr, m_pc);
         check_val("req_pc_is", 32'(pc_is_addr), 32'd1);
         check_val("req_pc_in", pc_in_addr, m_pc);
         check_val("req_instr", instr, m_instr);
         check_val("req_instr_pc", instr_pc, m_ipc);
         check_val("req_ivalid", 32'(instr_valid), 32'd0);
         check_val("req_busy", 32'(busy), 32'd1);
      end
      for (int i = 0; i <= rl; i++) begin
         @(negedge clk);
         imem_gnt    = 1'($urandom_range(0, 1));
         imem_rvalid = (i == rl);
         imem_rdata  = (i == rl) ? word : $urandom;
         halt        = 1'($urandom_range(0, 1));
         noise_exec();
         #1;
         check_val("wait_req", 32'(imem_req), 32'd0);
         check_val("wait_ivalid", 32'(instr_valid), 32'd0);
         check_val("wait_pc_in", pc_in_addr, m_pc);
         check_val("wait_fault", 32'(fault), 32'd0);
      end
      m_instr = word;
      m_ipc   = m_pc;
      for (int i = 0; i <= yl; i++) begin
         @(negedge clk);
         imem_gnt    = 1'b0;
         imem_rvalid = 1'($urandom_range(0, 1));
         imem_rdata  = $urandom;
         halt        = 1'($urandom_range(0, 1));
         noise_exec();
         exec_ready  = (i == yl);
         #1;
         check_val("iss_ivalid", 32'(instr_valid), 32'd1);
         check_val("iss_instr", instr, m_instr);
         check_val("iss_instr_pc", instr_pc, m_ipc);
         check_val("iss_pc_is", 32'(pc_is_addr), 32'd1);
         check_val("iss_pc_in", pc_in_addr, m_pc);
         check_val("iss_req", 32'(imem_req), 32'd0);
      end
      next_pc = m_pc;
      for (int i = 0; i <= dl; i++) begin
         @(negedge clk);
         imem_rvalid = 1'($urandom_range(0, 1));
         imem_rdata  = $urandom;
         exec_ready  = 1'($urandom_range(0, 1));
         exec_done   = (i == dl);
         if (i < dl) begin
            redirect_valid = 1'($urandom_range(0, 1));
            redirect_addr  = $urandom;
            halt           = 1'($urandom_range(0, 1));
         end else begin
            redirect_valid = redir;
            redirect_addr  = tgt;
            halt           = hlt;
         end
         #1;
         check_val("ex_ivalid", 32'(instr_valid), 32'd0);
         check_val("ex_instr", instr, m_instr);
         check_val("ex_req", 32'(imem_req), 32'd0);
         check_val("ex_busy", 32'(busy), 32'd1);
         if (i < dl) begin
            check_val("ex_pc_is", 32'(pc_is_addr), 32'd1);
            check_val("ex_pc_in", pc_in_addr, m_pc);
         end else if (redir && (tgt % 4 == 0)) begin
            check_val("done_redir_is", 32'(pc_is_addr), 32'd1);
            check_val("done_redir_in", pc_in_addr, tgt);
            next_pc = tgt;
         end else if (redir) begin
            check_val("done_misal_is", 32'(pc_is_addr), 32'd1);
            check_val("done_misal_in", pc_in_addr, m_pc);
         end else begin
            check_val("done_inc_is", 32'(pc_is_addr), 32'd0);
            next_pc = m_pc + 32'd4;
         end
      end
      m_pc = next_pc;
   endtask

   task automatic check_fault(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         imem_gnt    = 1'($urandom_range(0, 1));
         imem_rvalid = 1'($urandom_range(0, 1));
         imem_rdata  = $urandom;
         halt        = 1'($urandom_range(0, 1));
         noise_exec();
         #1;
         check_val("flt_fault", 32'(fault), 32'd1);
         check_val("flt_busy", 32'(busy), 32'd0);
         check_val("flt_req", 32'(imem_req), 32'd0);
         check_val("flt_ivalid", 32'(instr_valid), 32'd0);
         check_val("flt_pc_is", 32'(pc_is_addr), 32'd1);
         check_val("flt_pc_in", pc_in_addr, m_pc);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int          g, r;
      logic [31:0] t;
      reset_n = 1'b0;
      idle_inputs();
      m_pc    = RESET_PC;
      m_instr = 32'h0;
      m_ipc   = 32'h0;

      do_reset(1'b0);
      // Zero-wait sequential fetch.
      repeat (3) fetch_one(0, 0, 0, 0, 1'b0, 32'h0, 1'b0);
      // Aligned redirect, then fetch from the target.
      fetch_one(0, 0, 0, 0, 1'b1, 32'h8000_0100, 1'b0);
      fetch_one(1, 1, 0, 0, 1'b0, 32'h0, 1'b0);
      // Halt at completion, resume at PC+4.
      fetch_one(0, 0, 0, 0, 1'b0, 32'h0, 1'b1);
      do_halt(3);
      fetch_one(0, 0, 0, 0, 1'b0, 32'h0, 1'b0);
      // Execute stalls in ISSUE.
      fetch_one(0, 0, 5, 2, 1'b0, 32'h0, 1'b0);
      // Wait budget boundaries: last allowed cycle in REQ / in WAIT_DATA.
      fetch_one(MAX_WAIT - 2, 0, 0, 0, 1'b0, 32'h0, 1'b0);
      fetch_one(0, MAX_WAIT - 2, 0, 0, 1'b0, 32'h0, 1'b0);
      fetch_one(7, 7, 1, 1, 1'b0, 32'h0, 1'b0);

      repeat (40) begin
         g = $urandom_range(0, 3);
         if ($urandom_range(0, 7) == 0) g = $urandom_range(0, MAX_WAIT - 2);
         r = $urandom_range(0, MAX_WAIT - 2 - g);
         t = $urandom;
         t = t & ~32'h3;
         if ($urandom_range(0, 4) == 0) begin
            fetch_one(g, r, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), t, 1'b1);
            do_halt($urandom_range(1, 3));
         end else begin
            fetch_one(g, r, $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 3) == 0), t, 1'b0);
         end
      end

      // Reset in WAIT_DATA; the late response after release is dropped.
      @(negedge clk);
      idle_inputs();
      imem_gnt = 1'b1;
      #1;
      check_val("mid_req", 32'(imem_req), 32'd1);
      @(negedge clk);
      imem_gnt = 1'b0;
      #1;
      check_val("mid_wait", 32'(imem_req), 32'd0);
      do_reset(1'b0);
      fetch_one(0, 0, 0, 0, 1'b0, 32'h0, 1'b0);

      // Halt requested while IDLE.
      do_reset(1'b1);
      fetch_one(1, 0, 0, 0, 1'b0, 32'h0, 1'b0);

      // Grant never arrives: fault after MAX_WAIT REQ cycles.
      for (int i = 0; i < int'(MAX_WAIT); i++) begin
         @(negedge clk);
         idle_inputs();
         #1;
         check_val("tmo_req", 32'(imem_req), 32'd1);
         check_val("tmo_nofault", 32'(fault), 32'd0);
      end
      check_fault(4);

      // Response never arrives: REQ + WAIT_DATA share the same budget.
      do_reset(1'b0);
      @(negedge clk);
      idle_inputs();
      imem_gnt = 1'b1;
      #1;
      check_val("tmo2_req", 32'(imem_req), 32'd1);
      for (int i = 1; i < int'(MAX_WAIT); i++) begin
         @(negedge clk);
         idle_inputs();
         #1;
         check_val("tmo2_wait", 32'(imem_req), 32'd0);
         check_val("tmo2_nofault", 32'(fault), 32'd0);
      end
      check_fault(3);

      // Misaligned redirect: sticky fault, PC held, no more requests.
      do_reset(1'b0);
      fetch_one(2, 1, 1, 1, 1'b0, 32'h0, 1'b0);
      fetch_one(0, 0, 0, 0, 1'b1, 32'h8000_0102, 1'b0);
      check_fault(5);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Multi-cycle fetch/execute sequencer for the miniRV core. Owns the `pc` register's `is_addr`/`in_addr` inputs and decides each cycle whether the PC holds, increments by 4 or takes a redirect. Requests instructions from instruction memory, hands each one to the execute stage, and waits for completion before advancing. Sits between `pc`, the instruction-memory port and the execute unit.

## Interface
- `MAX_WAIT`, default 16: cycles allowed in REQ+WAIT_DATA combined before fault; range 2..255.
- `clk` in 1: core clock; all state changes on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `pc_addr` in 32: current PC (`pc.out_addr`).
- `pc_in_addr` out 32: to `pc.in_addr`.
- `pc_is_addr` out 1: to `pc.is_addr`; 1 = load `pc_in_addr`, 0 = PC+4.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: read data valid.
- `imem_rdata` in 32: instruction word.
- `instr_valid` out 1: instruction offered to execute.
- `instr` out 32: captured instruction.
- `instr_pc` out 32: PC of `instr`.
- `exec_ready` in 1: execute accepts `instr`.
- `exec_done` in 1: execute finished the current instruction.
- `redirect_valid` in 1: next PC is `redirect_addr` (sampled with `exec_done` only).
- `redirect_addr` in 32: branch/jump target.
- `halt` in 1: stop fetching.
- `busy` out 1: state not HALTED/FAULT.
- `fault` out 1: sticky error.

## Operation
- States: IDLE, REQ, WAIT_DATA, ISSUE, EXEC, HALTED, FAULT. Reset state IDLE.
- Default every cycle: `pc_is_addr`=1, `pc_in_addr`=`pc_addr` (hold). PC changes only in the EXEC completion cycle.
- IDLE: `halt` → HALTED, else → REQ.
- REQ: `imem_req`=1, `imem_addr`=`pc_addr`. `imem_gnt` → WAIT_DATA. `imem_rvalid` ignored.
- WAIT_DATA: `imem_rvalid` → latch `instr`←`imem_rdata`, `instr_pc`←`pc_addr`; → ISSUE.
- ISSUE: `instr_valid`=1; `exec_ready` → EXEC.
- EXEC: wait for `exec_done`. On done:
  - `redirect_valid`=1, `redirect_addr[1:0]`=0: `pc_is_addr`=1, `pc_in_addr`=`redirect_addr`.
  - `redirect_valid`=1, misaligned: PC held, → FAULT.
  - else `pc_is_addr`=0 (PC+4).
  - Next state HALTED if `halt`, else REQ.
- HALTED: PC held; `halt`=0 → REQ.
- FAULT: PC held, `fault`=1, `busy`=0; exits only on reset.
- Wait timer: cleared on entering REQ; counts each cycle in REQ/WAIT_DATA; reaching `MAX_WAIT` without the exiting event → FAULT.
- `halt` is sampled only in IDLE, at EXEC completion and in HALTED; an in-flight fetch always completes.

## Timing
- Reset values: `imem_req`=0, `instr_valid`=0, `instr`=0, `instr_pc`=0, `fault`=0, `busy`=1, `pc_is_addr`=1, `pc_in_addr`=`pc_addr`.
- Min cycles per instruction: 4 (gnt in the REQ cycle, rvalid in the first WAIT_DATA cycle, ready in the ISSUE cycle, done in the first EXEC cycle).
- New PC is visible on `pc_addr` one cycle after the `exec_done` cycle, which is the next REQ cycle.
- `instr`/`instr_pc` stable from ISSUE until the next rvalid capture.
- `imem_rvalid` arriving in any state other than WAIT_DATA is ignored, including the cycle after reset release.
- Reset mid-fetch: immediate return to IDLE, outputs to reset values; the late response is dropped.
- `exec_done` with `exec_ready` in ISSUE: done is ignored; completion counts only in EXEC.

## Structure
- `miniRV_pkg`: `fetch_state_t` enum; `INSTR_BYTES`=4; `FETCH_ALIGN_MASK`=32'h3.
- One sub-module, `wait_timer` (clear, enable, `MAX_WAIT` parameter, `expired` output, 8-bit counter); the FSM lives in `fetch_ctrl`.

## Test plan
- Zero-wait memory and execute, `pc` reset value 32'h8000_0000, 3 instructions → fetch addresses 8000_0000, 8000_0004, 8000_0008, 4 cycles apart; `instr_pc` matches.
- `exec_done` with `redirect_valid`=1, `redirect_addr`=8000_0100 → next `imem_addr`=8000_0100; misaligned 8000_0102 → `fault`=1, PC held, no further `imem_req`.
- `imem_gnt` held low for `MAX_WAIT`=16 cycles → FAULT on the 16th; with gnt on the 15th → normal completion.
- `halt`=1 at `exec_done` → PC advances by 4, HALTED, `busy`=0, no `imem_req`; deassert → REQ at the new PC.
- `reset_n` pulsed low in WAIT_DATA, `imem_rvalid` pulsed after release → ignored; fetch restarts in REQ at `pc_addr`.
- `exec_ready` stalled 5 cycles in ISSUE → `instr_valid` high throughout, `instr` stable, `pc_is_addr`=1 holding PC.
